stepper_cmd_ctrl: RTL and testbench

Multi-channel, parametrised stepper-motor controller driven by ASCII command bytes from the UART receiver. It supersedes the fixed two-motor, divided-clock step logic: all channels run on the system clock, and each channel has its own step-count target, direction and step-rate divider. An optional one-deep acknowledge byte stream goes back to the UART transmitter path. It sits between `uart_rx` and the motor driver pins.

---
 rtl/stepper_pkg.sv | 31 +++
 rtl/stepper_chan.sv | 98 +++++++++
 rtl/stepper_cmd_ctrl.sv | 166 ++++++++++++++++
 tb/tb_stepper_cmd_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stepper_pkg.sv
// Shared command/response encodings and channel state for the stepper command controller.
// Pure definitions: no latency, no flow control.
package stepper_pkg;

    localparam logic [7:0] CMD_DIGIT0 = 8'h30;  // '0'
    localparam logic [7:0] CMD_DIGIT9 = 8'h39;  // '9'
    localparam logic [7:0] CMD_TGT_LO = 8'h41;  // 'A'
    localparam logic [7:0] CMD_TGT_HI = 8'h48;  // 'H'
    localparam logic [7:0] CMD_FWD    = 8'h4E;  // 'N'
    localparam logic [7:0] CMD_REV    = 8'h52;  // 'R'
    localparam logic [7:0] CMD_START  = 8'h53;  // 'S'
    localparam logic [7:0] CMD_JOG    = 8'h4A;  // 'J'
    localparam logic [7:0] CMD_ABORT  = 8'h58;  // 'X'
    localparam logic [7:0] CMD_LF     = 8'h0A;
    localparam logic [7:0] CMD_CR     = 8'h0D;

    localparam logic [7:0] RESP_K = 8'h4B;
    localparam logic [7:0] RESP_E = 8'h45;

    typedef enum logic [1:0] {
        CH_IDLE = 2'd0,
        CH_RUN  = 2'd1,
        CH_JOG  = 2'd2
    } chan_state_e;

    // 'A' is one angle unit, 'H' is eight.
    function automatic logic [31:0] unit_target(input logic [7:0] b, input int spu);
        return (32'(b - CMD_TGT_LO) + 32'd1) * 32'(spu);
    endfunction

endpackage

// File: rtl/stepper_chan.sv
// One motor channel: step divider, step counter, IDLE/RUN/JOG FSM and pin registers.
// Commands take effect at the next edge; first step rise one cycle after entering RUN/JOG.
// No backpressure: the parser only issues commands the channel can accept.
module stepper_chan
    import stepper_pkg::*;
#(
    parameter int CNT_W    = 16,
    parameter int DIV_W    = 24,
    parameter int HALF_DIV = 25000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             jog,
    input  logic             abort,
    input  logic             tgt_wr,
    input  logic [CNT_W-1:0] tgt,
    input  logic             dir_wr,
    input  logic             dir_set,
    output logic             step,
    output logic             dir,
    output logic             enable_n,
    output logic             busy,
    output logic             done
);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(HALF_DIV - 1);

    chan_state_e      state;
    logic [DIV_W-1:0] div_cnt;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] target;
    logic             step_q;
    logic             dir_q;
    logic             done_q;
    logic             half_end;

    assign half_end = (div_cnt == DIV_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= CH_IDLE;
            div_cnt  <= DIV_LAST;
            step_cnt <= '0;
            target   <= '0;
            step_q   <= 1'b0;
            dir_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (tgt_wr) target <= tgt;
            if (dir_wr) dir_q  <= dir_set;

            if (abort) begin
                state  <= CH_IDLE;
                step_q <= 1'b0;
            end else begin
                case (state)
                    CH_IDLE: begin
                        // Parked at end-of-low-half so the first active cycle raises step.
                        div_cnt  <= DIV_LAST;
                        step_cnt <= '0;
                        step_q   <= 1'b0;
                        if (jog) begin
                            state <= CH_JOG;
                        end else if (start) begin
                            if (target == '0) done_q <= 1'b1;
                            else              state  <= CH_RUN;
                        end
                    end
                    default: begin
                        if (half_end) begin
                            div_cnt <= '0;
                            if (step_q) begin
                                step_q <= 1'b0;
                            end else if (state == CH_RUN && step_cnt == target) begin
                                state  <= CH_IDLE;
                                done_q <= 1'b1;
                            end else begin
                                step_q   <= 1'b1;
                                step_cnt <= step_cnt + 1'b1;
                            end
                        end else begin
                            div_cnt <= div_cnt + 1'b1;
                        end
                    end
                endcase
            end
        end
    end

    assign step     = step_q;
    assign dir      = dir_q;
    assign busy     = (state != CH_IDLE);
    assign enable_n = (state == CH_IDLE);
    assign done     = done_q;

endmodule

// File: rtl/stepper_cmd_ctrl.sv
// ASCII command parser, channel select and optional 'K'/'E' response register (STEPPER_ACK_EN).
// A strobed byte updates state and ack_valid at the next edge.
// One-deep response: a response arriving while ack_valid is high is dropped.
module stepper_cmd_ctrl
    import stepper_pkg::*;
#(
    parameter int NUM_CH         = 2,
    parameter int CNT_W          = 16,
    parameter int DIV_W          = 24,
    parameter int HALF_DIV       = 25000,
    parameter int STEPS_PER_UNIT = 512
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        rx_data,
    input  logic              rx_data_en,
    input  logic              stop_n,
    output logic [NUM_CH-1:0] step,
    output logic [NUM_CH-1:0] dir,
    output logic [NUM_CH-1:0] enable_n,
    output logic [NUM_CH-1:0] busy,
    output logic [NUM_CH-1:0] done,
    output logic [7:0]        ack_data,
    output logic              ack_valid,
    input  logic              ack_ready
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [SEL_W-1:0]  sel;
    logic [7:0]        digit;
    logic              sel_busy;
    logic              sel_wr;
    logic              resp_vld;
    logic [7:0]        resp_byte;
    logic              start_c;
    logic              jog_c;
    logic              abort_c;
    logic              tgt_wr_c;
    logic              dir_wr_c;
    logic              dir_val;
    logic [CNT_W-1:0]  tgt_val;
    logic [NUM_CH-1:0] start_v;
    logic [NUM_CH-1:0] jog_v;
    logic [NUM_CH-1:0] abort_v;
    logic [NUM_CH-1:0] tgt_wr_v;
    logic [NUM_CH-1:0] dir_wr_v;

    assign digit    = rx_data - CMD_DIGIT0;
    assign tgt_val  = CNT_W'(unit_target(rx_data, STEPS_PER_UNIT));
    assign sel_busy = busy[sel];

    always_comb begin
        resp_vld  = 1'b0;
        resp_byte = RESP_K;
        sel_wr    = 1'b0;
        start_c   = 1'b0;
        jog_c     = 1'b0;
        abort_c   = 1'b0;
        tgt_wr_c  = 1'b0;
        dir_wr_c  = 1'b0;
        dir_val   = 1'b0;
        if (rx_data_en) begin
            resp_vld = 1'b1;
            if (rx_data >= CMD_DIGIT0 && rx_data <= CMD_DIGIT9) begin
                if (32'(digit) < 32'(NUM_CH)) sel_wr    = 1'b1;
                else                          resp_byte = RESP_E;
            end else if (rx_data >= CMD_TGT_LO && rx_data <= CMD_TGT_HI) begin
                if (sel_busy) resp_byte = RESP_E;
                else          tgt_wr_c  = 1'b1;
            end else begin
                case (rx_data)
                    CMD_FWD, CMD_REV: begin
                        if (sel_busy) begin
                            resp_byte = RESP_E;
                        end else begin
                            dir_wr_c = 1'b1;
                            dir_val  = (rx_data == CMD_FWD);
                        end
                    end
                    // A concurrent stop wins, so starts are refused rather than lost silently.
                    CMD_START: begin
                        if (sel_busy || !stop_n) resp_byte = RESP_E;
                        else                     start_c   = 1'b1;
                    end
                    CMD_JOG: begin
                        if (sel_busy || !stop_n) resp_byte = RESP_E;
                        else                     jog_c     = 1'b1;
                    end
                    CMD_ABORT:      abort_c   = 1'b1;
                    CMD_LF, CMD_CR: resp_vld  = 1'b0;
                    default:        resp_byte = RESP_E;
                endcase
            end
        end
    end

    always_comb begin
        start_v  = '0;
        jog_v    = '0;
        abort_v  = '0;
        tgt_wr_v = '0;
        dir_wr_v = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            start_v[c]  = start_c  && (sel == SEL_W'(c));
            jog_v[c]    = jog_c    && (sel == SEL_W'(c));
            tgt_wr_v[c] = tgt_wr_c && (sel == SEL_W'(c));
            dir_wr_v[c] = dir_wr_c && (sel == SEL_W'(c));
            abort_v[c]  = !stop_n || (abort_c && (sel == SEL_W'(c)));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n)      sel <= '0;
        else if (sel_wr) sel <= digit[SEL_W-1:0];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        stepper_chan #(
            .CNT_W    (CNT_W),
            .DIV_W    (DIV_W),
            .HALF_DIV (HALF_DIV)
        ) u_chan (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start_v[g]),
            .jog      (jog_v[g]),
            .abort    (abort_v[g]),
            .tgt_wr   (tgt_wr_v[g]),
            .tgt      (tgt_val),
            .dir_wr   (dir_wr_v[g]),
            .dir_set  (dir_val),
            .step     (step[g]),
            .dir      (dir[g]),
            .enable_n (enable_n[g]),
            .busy     (busy[g]),
            .done     (done[g])
        );
    end

`ifdef STEPPER_ACK_EN
    logic       ack_v_q;
    logic [7:0] ack_d_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ack_v_q <= 1'b0;
            ack_d_q <= 8'h00;
        end else if (ack_v_q) begin
            if (ack_ready) ack_v_q <= 1'b0;
        end else if (resp_vld) begin
            ack_v_q <= 1'b1;
            ack_d_q <= resp_byte;
        end
    end

    assign ack_valid = ack_v_q;
    assign ack_data  = ack_d_q;
`else
    logic unused_ack;
    assign unused_ack = ack_ready ^ resp_vld ^ (^resp_byte);
    assign ack_valid  = 1'b0;
    assign ack_data   = 8'h00;
`endif

endmodule

// File: tb/tb_stepper_cmd_ctrl.sv
// Directed bench for stepper_cmd_ctrl with HALF_DIV=4, STEPS_PER_UNIT=2, two channels.
module tb_stepper_cmd_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_data_en = 1'b0;
    logic       stop_n = 1'b1;
    logic [1:0] step, dir, enable_n, busy, done;
    logic [7:0] ack_data;
    logic       ack_valid;
    logic       ack_ready = 1'b1;

    int n_cmp = 0;
    int n_bad = 0;
    int ack_seen = 0;

    always #5 clk = ~clk;

    stepper_cmd_ctrl #(
        .NUM_CH(2), .CNT_W(16), .DIV_W(24), .HALF_DIV(4), .STEPS_PER_UNIT(2)
    ) dut (
        .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_data_en(rx_data_en),
        .stop_n(stop_n), .step(step), .dir(dir), .enable_n(enable_n),
        .busy(busy), .done(done), .ack_data(ack_data), .ack_valid(ack_valid),
        .ack_ready(ack_ready)
    );

    always @(negedge clk) if (rst_n && ack_valid) ack_seen++;

    typedef struct {
        logic [7:0] b;
        logic       av;
        logic [7:0] ad;
        logic [1:0] busy;
        logic [1:0] dir;
    } vec_t;

    vec_t tbl[10];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_data    = b;
        rx_data_en = 1'b1;
        tick();
        rx_data_en = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    // Response check: without the ack path the outputs must stay quiet.
    task automatic chk_ack(input string nm, input logic v, input logic [7:0] d);
`ifdef STEPPER_ACK_EN
        chk({nm, "_ack_valid"}, 32'(ack_valid), 32'(v));
        if (v) chk({nm, "_ack_data"}, 32'(ack_data), 32'(d));
`else
        chk({nm, "_ack_valid"}, 32'(ack_valid), 32'(1'b0 & v & d[0]));
`endif
    endtask

    initial begin
        int rises, first_rise, bad_high, bad_low, hi_run, last_fall;
        int done_at, done_cnt, busy_at_done, busy33, ch0_act, cnt;
        logic prev;

        tbl[0] = '{8'h37, 1'b1, 8'h45, 2'b00, 2'b00};  // '7' out of range
        tbl[1] = '{8'h4E, 1'b1, 8'h4B, 2'b00, 2'b01};  // 'N' still lands on ch0
        tbl[2] = '{8'h52, 1'b1, 8'h4B, 2'b00, 2'b00};  // 'R'
        tbl[3] = '{8'h5A, 1'b1, 8'h45, 2'b00, 2'b00};  // 'Z'
        tbl[4] = '{8'h0D, 1'b0, 8'h00, 2'b00, 2'b00};  // CR ignored
        tbl[5] = '{8'h0A, 1'b0, 8'h00, 2'b00, 2'b00};  // LF ignored
        tbl[6] = '{8'h31, 1'b1, 8'h4B, 2'b00, 2'b00};  // '1'
        tbl[7] = '{8'h42, 1'b1, 8'h4B, 2'b00, 2'b00};  // 'B' -> target 4
        tbl[8] = '{8'h4E, 1'b1, 8'h4B, 2'b00, 2'b10};  // 'N' on ch1
        tbl[9] = '{8'h48, 1'b1, 8'h4B, 2'b00, 2'b10};  // 'H' then 'B' again below

        tick(); tick();
        chk("rst_step", 32'(step), 32'h0);
        chk("rst_dir", 32'(dir), 32'h0);
        chk("rst_enable_n", 32'(enable_n), 32'h3);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ack_valid", 32'(ack_valid), 32'h0);
        chk("rst_ack_data", 32'(ack_data), 32'h0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 10; i++) begin
            send(tbl[i].b);
            chk_ack($sformatf("vec%0d", i), tbl[i].av, tbl[i].ad);
            chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].busy));
            chk($sformatf("vec%0d_dir", i), 32'(dir), 32'(tbl[i].dir));
            tick();
        end
        send(8'h42);
        tick();

        // Counted move on ch1: 4 steps of 4 high / 4 low, done 34 cycles after 'S'.
        send(8'h53);
        chk_ack("start1", 1'b1, 8'h4B);
        chk("start1_busy", 32'(busy), 32'h2);
        chk("start1_enable_n", 32'(enable_n), 32'h1);
        rises = 0; first_rise = -1; bad_high = 0; bad_low = 0; hi_run = 0; last_fall = -1;
        done_at = -1; done_cnt = 0; busy_at_done = 1; busy33 = 0; ch0_act = 0; prev = 1'b0;
        for (int c = 1; c <= 45; c++) begin
            if (step[1] && !prev) begin
                rises++;
                if (first_rise < 0) first_rise = c;
                if (last_fall >= 0 && c - last_fall != 4) bad_low++;
            end
            if (step[1]) hi_run++;
            else if (prev) begin
                if (hi_run != 4) bad_high++;
                hi_run = 0;
                last_fall = c;
            end
            if (done[1]) begin
                done_cnt++;
                if (done_at < 0) begin done_at = c; busy_at_done = 32'(busy[1]); end
            end
            if (c == 33) busy33 = 32'(busy[1]);
            if (step[0] || busy[0] || done[0]) ch0_act++;
            prev = step[1];
            tick();
        end
        chk("move_rises", rises, 4);
        chk("move_first_rise", first_rise, 2);
        chk("move_high_len_bad", bad_high, 0);
        chk("move_low_len_bad", bad_low, 0);
        chk("move_done_cycle", done_at, 34);
        chk("move_done_count", done_cnt, 1);
        chk("move_busy_at_done", busy_at_done, 0);
        chk("move_busy_before_done", busy33, 1);
        chk("move_dir1", 32'(dir[1]), 1);
        chk("move_ch0_quiet", ch0_act, 0);
        chk("move_end_enable_n", 32'(enable_n), 32'h3);

        // Zero target on ch0: immediate done, no steps.
        send(8'h30); tick();
        send(8'h53);
        chk_ack("zero_start", 1'b1, 8'h4B);
        chk("zero_done", 32'(done), 32'h1);
        chk("zero_busy", 32'(busy), 32'h0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (step[0] || done[0]) cnt++;
        end
        chk("zero_quiet_after", cnt, 0);

        // Jog ch0, refused direction change, abort.
        send(8'h4A);
        chk_ack("jog0", 1'b1, 8'h4B);
        chk("jog0_busy", 32'(busy[0]), 1);
        chk("jog0_enable_n", 32'(enable_n[0]), 0);
        tick();
        send(8'h4E);
        chk_ack("jog0_dir_refused", 1'b1, 8'h45);
        chk("jog0_dir_kept", 32'(dir[0]), 0);
        cnt = 0; rises = 0; prev = step[0];
        for (int c = 0; c < 20; c++) begin
            tick();
            if (done[0]) cnt++;
            if (step[0] && !prev) rises++;
            prev = step[0];
        end
        chk("jog0_no_done", cnt, 0);
        chk("jog0_stepping", 32'(rises > 1), 1);
        send(8'h58);
        chk_ack("abort0", 1'b1, 8'h4B);
        chk("abort0_step", 32'(step[0]), 0);
        chk("abort0_enable_n", 32'(enable_n[0]), 1);
        chk("abort0_busy", 32'(busy[0]), 0);
        chk("abort0_done", 32'(done[0]), 0);
        cnt = 0;
        for (int c = 0; c < 5; c++) begin
            tick();
            if (done[0] || step[0]) cnt++;
        end
        chk("abort0_quiet_after", cnt, 0);

        // Jog both, then stop_n together with an 'S' byte.
        send(8'h4A); tick();
        send(8'h31); tick();
        send(8'h4A); tick();
        chk("both_jog_busy", 32'(busy), 32'h3);
        stop_n = 1'b0; rx_data = 8'h53; rx_data_en = 1'b1;
        tick();
        stop_n = 1'b1; rx_data_en = 1'b0;
        chk("stop_busy", 32'(busy), 32'h0);
        chk("stop_enable_n", 32'(enable_n), 32'h3);
        chk("stop_step", 32'(step), 32'h0);
        chk_ack("stop_with_s", 1'b1, 8'h45);
        tick();
        stop_n = 1'b0; rx_data = 8'h4A; rx_data_en = 1'b1;
        tick();
        stop_n = 1'b1; rx_data_en = 1'b0;
        chk_ack("stop_with_j", 1'b1, 8'h45);
        chk("stop_j_refused", 32'(busy), 32'h0);
        tick();
        chk("stop_j_refused_later", 32'(busy), 32'h0);

`ifdef STEPPER_ACK_EN
        ack_ready = 1'b0;
        send(8'h30);
        chk_ack("hold_first", 1'b1, 8'h4B);
        tick();
        send(8'h5A);
        chk_ack("hold_second", 1'b1, 8'h4B);
        tick(); tick();
        chk_ack("hold_still", 1'b1, 8'h4B);
        ack_ready = 1'b1;
        tick();
        chk("hold_released", 32'(ack_valid), 0);
        send(8'h5A);
        chk_ack("after_hold", 1'b1, 8'h45);
        tick();
`endif

        // Reset in the middle of a counted move on ch1.
        send(8'h31); tick();
        send(8'h53); tick();
        for (int c = 0; c < 5; c++) tick();
        chk("midrst_pre_busy", 32'(busy), 32'h2);
        rst_n = 1'b0;
        tick();
        chk("midrst_step", 32'(step), 32'h0);
        chk("midrst_dir", 32'(dir), 32'h0);
        chk("midrst_enable_n", 32'(enable_n), 32'h3);
        chk("midrst_busy", 32'(busy), 32'h0);
        chk("midrst_done", 32'(done), 32'h0);
        chk("midrst_ack_valid", 32'(ack_valid), 0);
        rst_n = 1'b1;
        tick();
        send(8'h53);
        chk("midrst_sel_tgt_cleared", 32'(done), 32'h1);
        tick();

`ifdef STEPPER_ACK_EN
        chk("ack_seen_nonzero", 32'(ack_seen != 0), 1);
`else
        chk("ack_never_valid", ack_seen, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
